pipeline_stall_controller: RTL

//  Central freeze/flush sequencer for the 5-stage ARM pipeline.

---
 rtl/pipeline_stall_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush sequencer: merges hazard, branch and SRAM handshake into per-stage controls.
// Controls are Mealy (same cycle); SRAM waits tracked by a RUN/MEM_WAIT FSM with timeout; stats saturate.
module pipeline_stall_controller #(
  parameter int STAT_WIDTH  = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic                  sram_ready,
  input  logic                  stat_clr,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  bubble_id_exe,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  freeze_all,
  output logic                  mem_timeout,
  output logic [STAT_WIDTH-1:0] stall_cycles,
  output logic [STAT_WIDTH-1:0] mem_wait_cycles,
  output logic [STAT_WIDTH-1:0] flush_events
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0]        WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX  = {STAT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic [STAT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [STAT_WIDTH-1:0] mem_wait_cycles_q, mem_wait_cycles_d;
  logic [STAT_WIDTH-1:0] flush_events_q, flush_events_d;

  logic mem_req;
  logic frz;
  logic flush;
  logic hz_stall;

  assign mem_req = mem_r_en | mem_w_en;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    frz           = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !sram_ready) begin
          frz        = 1'b1;
          wait_cnt_d = WCW'(1);
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_req || sram_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Forced release: let the pipeline move and flag the stuck access.
          mem_timeout_d = 1'b1;
          state_d       = RUN;
          wait_cnt_d    = '0;
        end else begin
          frz        = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Priority: memory freeze over branch flush over hazard bubble.
  assign flush    = !rst && !frz && branch_taken;
  assign hz_stall = !rst && !frz && !branch_taken && hazard;

  assign freeze_all    = !rst && frz;
  assign freeze_pc     = hz_stall;
  assign freeze_if_id  = hz_stall;
  assign bubble_id_exe = hz_stall;
  assign flush_if_id   = flush;
  assign flush_id_exe  = flush;

  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    mem_wait_cycles_d = mem_wait_cycles_q;
    flush_events_d    = flush_events_q;
    if (stat_clr) begin
      stall_cycles_d    = '0;
      mem_wait_cycles_d = '0;
      flush_events_d    = '0;
    end else begin
      if (hz_stall && stall_cycles_q != STAT_MAX)      stall_cycles_d    = stall_cycles_q + 1'b1;
      if (freeze_all && mem_wait_cycles_q != STAT_MAX) mem_wait_cycles_d = mem_wait_cycles_q + 1'b1;
      if (flush && flush_events_q != STAT_MAX)         flush_events_d    = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= RUN;
      wait_cnt_q        <= '0;
      mem_timeout_q     <= 1'b0;
      stall_cycles_q    <= '0;
      mem_wait_cycles_q <= '0;
      flush_events_q    <= '0;
    end else begin
      state_q           <= state_d;
      wait_cnt_q        <= wait_cnt_d;
      mem_timeout_q     <= mem_timeout_d;
      stall_cycles_q    <= stall_cycles_d;
      mem_wait_cycles_q <= mem_wait_cycles_d;
      flush_events_q    <= flush_events_d;
    end
  end

  assign mem_timeout     = mem_timeout_q;
  assign stall_cycles    = stall_cycles_q;
  assign mem_wait_cycles = mem_wait_cycles_q;
  assign flush_events    = flush_events_q;

endmodule
